// File: rtl/shaft_drive.sv
// shaft_drive: per-car shaft model answering one-floor move requests with timed inc/dec arrival pulses and a door interlock
module shaft_drive #(
    parameter int FLOORS        = 3,
    parameter int FLOOR_BITS    = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int LEVEL_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLOOR_BITS-1:0] init_floor,
    input  logic                  move_req,
    input  logic                  move_dir,
    input  logic                  door_closed,
    output logic                  inc,
    output logic                  dec,
    output logic [FLOOR_BITS-1:0] location,
    output logic                  moving,
    output logic                  reject,
    output logic                  fault
);
    typedef enum logic [2:0] {IDLE, TRAVEL, LEVEL, ARRIVE, FAULT} state_t;

    localparam logic [FLOOR_BITS-1:0] TOP = FLOOR_BITS'(FLOORS - 1);

    state_t                state;
    logic [7:0]            cnt;
    logic                  dir_q;
    logic                  legal;
    logic [FLOOR_BITS-1:0] start_floor;

    assign start_floor = (init_floor > TOP) ? TOP : init_floor;
    assign legal       = move_dir ? (location != '0) : (location != TOP);

    // outputs are pure decodes of the registered state
    assign inc    = (state == ARRIVE) && !dir_q;
    assign dec    = (state == ARRIVE) && dir_q;
    assign moving = (state == TRAVEL) || (state == LEVEL) || (state == ARRIVE);
    assign fault  = (state == FAULT);

    // move sequencing: door-open while moving wins over every timer transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            location <= start_floor;
            dir_q    <= 1'b0;
            cnt      <= 8'd0;
            reject   <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                IDLE: if (move_req && door_closed) begin
                    if (legal) begin
                        dir_q <= move_dir;
                        cnt   <= 8'(TRAVEL_CYCLES - 1);
                        state <= TRAVEL;
                    end else begin
                        reject <= 1'b1;
                    end
                end
                TRAVEL: if (!door_closed) state <= FAULT;
                        else if (cnt == 8'd0) begin
                            cnt   <= 8'(LEVEL_CYCLES - 1);
                            state <= LEVEL;
                        end else cnt <= cnt - 8'd1;
                LEVEL:  if (!door_closed) state <= FAULT;
                        else if (cnt == 8'd0) state <= ARRIVE;
                        else cnt <= cnt - 8'd1;
                ARRIVE: if (!door_closed) state <= FAULT;
                        else begin
                            location <= dir_q ? location - 1'b1 : location + 1'b1;
                            state    <= IDLE;
                        end
                FAULT:  state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shaft_drive.sv
// tb_shaft_drive: scoreboard bench for shaft_drive (default timing plus a fast-timing instance)
module tb_shaft_drive;
    logic       clk = 1'b0;
    logic       reset, reset2;
    logic [1:0] init_floor;
    logic       move_req, move_dir, door_closed;
    logic       inc, dec, moving, reject, fault;
    logic [1:0] location;
    logic       req2, dir2, one;
    logic       inc2, dec2, moving2, reject2, fault2;
    logic [1:0] loc2;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    typedef struct { logic down; int due; } exp_t;
    exp_t sb[$];
    exp_t e;

    shaft_drive dut (
        .clk(clk), .reset(reset), .init_floor(init_floor), .move_req(move_req),
        .move_dir(move_dir), .door_closed(door_closed), .inc(inc), .dec(dec),
        .location(location), .moving(moving), .reject(reject), .fault(fault)
    );

    shaft_drive #(.TRAVEL_CYCLES(1), .LEVEL_CYCLES(1)) fast (
        .clk(clk), .reset(reset2), .init_floor(2'd0), .move_req(req2),
        .move_dir(dir2), .door_closed(one), .inc(inc2), .dec(dec2),
        .location(loc2), .moving(moving2), .reject(reject2), .fault(fault2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // scoreboard: every arrival pulse must match the oldest expected move in direction and cycle
    always @(negedge clk) begin
        if (!reset && (inc || dec)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pulse: unexpected inc=%b dec=%b at cycle %0d, required none", inc, dec, cyc);
            end else begin
                e = sb.pop_front();
                if (inc !== !e.down || dec !== e.down || cyc != e.due) begin
                    fails++;
                    $display("FAIL pulse: got inc=%b dec=%b at cycle %0d, required inc=%b dec=%b at cycle %0d",
                             inc, dec, cyc, !e.down, e.down, e.due);
                end
            end
        end
    end

    task automatic start_move(input logic down);
        @(negedge clk);
        move_dir    = down;
        door_closed = 1'b1;
        move_req    = 1'b1;
        sb.push_back('{down, cyc + 1 + 5});
    endtask

    task automatic wait_pulse(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (inc || dec) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        init_floor  = 2'd0;
        move_req    = 1'b0;
        move_dir    = 1'b0;
        door_closed = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        tests++;
        if (location !== 2'd0 || inc !== 1'b0 || dec !== 1'b0 || moving !== 1'b0 || reject !== 1'b0 || fault !== 1'b0) begin
            fails++;
            $display("FAIL reset: loc=%0d inc=%b dec=%b mov=%b rej=%b flt=%b, required 0 0 0 0 0 0",
                     location, inc, dec, moving, reject, fault);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (moving !== 1'b0 || location !== 2'd0) begin
            fails++;
            $display("FAIL reset_idle: mov=%b loc=%0d, required 0 0", moving, location);
        end
    endtask

    task automatic test_up_move;
        bit seen;
        start_move(1'b0);
        @(negedge clk);
        tests++;
        if (moving !== 1'b1) begin
            fails++;
            $display("FAIL up_moving: got %b, required 1", moving);
        end
        wait_pulse(seen);
        move_req = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL up_pulse: got no pulse, required inc");
        end
        @(negedge clk);
        tests++;
        if (location !== 2'd1 || moving !== 1'b0 || inc !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL up_done: loc=%0d mov=%b inc=%b pending=%0d, required 1 0 0 0",
                     location, moving, inc, sb.size());
        end
    endtask

    task automatic test_traverse;
        bit seen;
        start_move(1'b0);
        wait_pulse(seen);
        move_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!seen || location !== 2'd2) begin
            fails++;
            $display("FAIL up_to_top: seen=%b loc=%0d, required 1 2", seen, location);
        end
        start_move(1'b1);
        wait_pulse(seen);
        move_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!seen || location !== 2'd1) begin
            fails++;
            $display("FAIL down_move: seen=%b loc=%0d, required 1 1", seen, location);
        end
        start_move(1'b0);
        wait_pulse(seen);
        move_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!seen || location !== 2'd2) begin
            fails++;
            $display("FAIL up_again: seen=%b loc=%0d, required 1 2", seen, location);
        end
        move_dir = 1'b0;
        move_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (reject !== 1'b1 || moving !== 1'b0 || location !== 2'd2) begin
                fails++;
                $display("FAIL reject_top[%0d]: rej=%b mov=%b loc=%0d, required 1 0 2", i, reject, moving, location);
            end
        end
        move_req = 1'b0;
        @(negedge clk);
        tests++;
        if (reject !== 1'b0) begin
            fails++;
            $display("FAIL reject_clear: got %b, required 0", reject);
        end
    endtask

    task automatic test_door_interlock;
        bit ok = 1'b1;
        start_move(1'b1);
        repeat (2) @(negedge clk);
        door_closed = 1'b0;
        sb.delete();
        @(negedge clk);
        tests++;
        if (fault !== 1'b1 || moving !== 1'b0 || location !== 2'd2) begin
            fails++;
            $display("FAIL door_fault: flt=%b mov=%b loc=%0d, required 1 0 2", fault, moving, location);
        end
        move_req    = 1'b0;
        door_closed = 1'b1;
        @(negedge clk);
        move_req = 1'b1;
        move_dir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fault !== 1'b1 || moving !== 1'b0 || reject !== 1'b0 || location !== 2'd2) ok = 1'b0;
        end
        move_req = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL fault_sticky: flt=%b mov=%b rej=%b loc=%0d, required 1 0 0 2", fault, moving, reject, location);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (fault !== 1'b0 || location !== 2'd0) begin
            fails++;
            $display("FAIL fault_reset: flt=%b loc=%0d, required 0 0", fault, location);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_door_wait;
        bit ok = 1'b1;
        bit seen;
        @(negedge clk);
        door_closed = 1'b0;
        move_dir    = 1'b0;
        move_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (moving !== 1'b0 || reject !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL door_wait: mov=%b rej=%b, required 0 0", moving, reject);
        end
        door_closed = 1'b1;
        sb.push_back('{1'b0, cyc + 1 + 5});
        ok = 1'b1;
        for (int i = 0; i < 30 && !(inc || dec); i++) begin
            @(negedge clk);
            if (reject !== 1'b0) ok = 1'b0;
        end
        seen = inc;
        move_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!seen || !ok || location !== 2'd1) begin
            fails++;
            $display("FAIL door_accept: seen=%b no_reject=%b loc=%0d, required 1 1 1", seen, ok, location);
        end
    endtask

    task automatic test_clamp_reset_mid;
        bit ok = 1'b1;
        init_floor = 2'd3;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (location !== 2'd2) begin
            fails++;
            $display("FAIL clamp: got %0d, required 2", location);
        end
        start_move(1'b1);
        repeat (5) @(negedge clk);
        tests++;
        if (moving !== 1'b1 || dec !== 1'b0) begin
            fails++;
            $display("FAIL mid_level: mov=%b dec=%b, required 1 0", moving, dec);
        end
        reset = 1'b1;
        sb.delete();
        #1;
        tests++;
        if (location !== 2'd2 || moving !== 1'b0 || dec !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: loc=%0d mov=%b dec=%b, required 2 0 0", location, moving, dec);
        end
        move_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dec !== 1'b0 || location !== 2'd2) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_lost: dec=%b loc=%0d, required 0 2", dec, location);
        end
    endtask

    task automatic test_back_to_back;
        int a0;
        int p[$];
        bit bad_dec = 1'b0;
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        dir2 = 1'b0;
        req2 = 1'b1;
        a0   = cyc;
        for (int i = 0; i < 20 && p.size() < 2; i++) begin
            @(negedge clk);
            if (dec2) bad_dec = 1'b1;
            if (inc2) p.push_back(cyc);
        end
        req2 = 1'b0;
        @(negedge clk);
        tests++;
        if (p.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d pulses, required 2", p.size());
        end else begin
            tests++;
            if (p[0] != a0 + 3 || p[1] != a0 + 7) begin
                fails++;
                $display("FAIL b2b_timing: pulses at +%0d +%0d, required +3 +7", p[0] - a0, p[1] - a0);
            end
        end
        tests++;
        if (loc2 !== 2'd2 || bad_dec || moving2 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_final: loc=%0d dec_seen=%b mov=%b, required 2 0 0", loc2, bad_dec, moving2);
        end
    endtask

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        req2   = 1'b0;
        dir2   = 1'b0;
        one    = 1'b1;
        test_reset();
        test_up_move();
        test_traverse();
        test_door_interlock();
        test_door_wait();
        test_clamp_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end
endmodule

// File: doc/shaft_drive.md
# shaft_drive

Per-car shaft and motor model: the responding end of the car's movement interface. A car requests a one-floor move; this block runs the travel and levelling timers and answers with the single-cycle `inc`/`dec` arrival pulse, the same pulse `main_control` consumes. The arrival pulse replaces the nondeterministic `r_stop` arrival with a deterministic, timed response. The block also enforces the door interlock: moving with the door open is a fault.

## Interface
- `FLOORS`, default 3: number of floors, numbered 0..FLOORS-1.
- `FLOOR_BITS`, default 2: width of a floor number.
- `TRAVEL_CYCLES`, default 4: cycles spent in TRAVEL per floor; legal range 1..255.
- `LEVEL_CYCLES`, default 1: cycles spent in LEVEL before arrival; legal range 1..255.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `init_floor`, input, FLOOR_BITS: starting floor, loaded on reset. Static during operation. Values ≥ FLOORS are clamped to FLOORS-1.
- `move_req`, input, 1: request a one-floor move. Held high until the arrival pulse.
- `move_dir`, input, 1: direction of the move, 0 = UP, 1 = DOWN. Sampled at accept.
- `door_closed`, input, 1: car door is fully CLOSED.
- `inc`, output, 1: one-cycle pulse, arrived one floor up.
- `dec`, output, 1: one-cycle pulse, arrived one floor down.
- `location`, output, FLOOR_BITS: current floor.
- `moving`, output, 1: high in TRAVEL, LEVEL and ARRIVE.
- `reject`, output, 1: one-cycle pulse, illegal request ignored.
- `fault`, output, 1: door-interlock fault, sticky.

## Operation
States: IDLE, TRAVEL, LEVEL, ARRIVE, FAULT. An 8-bit down-counter `cnt` and a registered direction `dir_q` support them.

- **IDLE**
  - Accept when `move_req && door_closed` and the move is legal. Legal means UP with `location != FLOORS-1`, or DOWN with `location != 0`.
  - On accept: `dir_q <= move_dir`, `cnt <= TRAVEL_CYCLES-1`, go to TRAVEL.
  - Illegal request (`move_req && door_closed`, move not legal): stay in IDLE and pulse `reject` the next cycle. `reject` repeats every cycle the request is held.
  - `move_req` with `!door_closed`: no accept, no reject, wait.
- **TRAVEL**
  - If `cnt == 0`: `cnt <= LEVEL_CYCLES-1`, go to LEVEL. Otherwise decrement `cnt`.
- **LEVEL**
  - If `cnt == 0`, go to ARRIVE. Otherwise decrement `cnt`.
- **ARRIVE**
  - `inc = (dir_q == UP)`, `dec = (dir_q == DOWN)`.
  - At the closing edge: `location <= location ± 1`, go to IDLE.
- **FAULT**
  - Entered from TRAVEL, LEVEL or ARRIVE whenever `door_closed == 0`. Door-open has priority over all other transitions in those states.
  - The ARRIVE pulse and location update are suppressed; `location` freezes.
  - `fault = 1` and `moving = 0`. All requests are ignored.
  - Only `reset` exits FAULT.
- **Move commitment**
  - `move_req` falling during a move is ignored; the move always completes.
  - `move_dir` changes after accept are ignored.
- **Outputs**
  - `inc`, `dec`, `moving` and `fault` are decoded from registered state only; there is no combinational path from inputs.
  - `reject` is a registered pulse.

## Timing
- **Reset values:** state IDLE, `location = min(init_floor, FLOORS-1)`, `dir_q = UP`, `cnt = 0`. Outputs `inc = dec = moving = reject = fault = 0`.
- **Arrival latency:** with the accept at edge E0, `inc`/`dec` is high in the cycle after edge E0+TRAVEL_CYCLES+LEVEL_CYCLES. With the defaults this is 5 edges later.
  - `location` changes at the next edge.
  - `moving` rises in the cycle after E0.
- **Back-to-back moves:** minimum one IDLE cycle between an ARRIVE and the next accept. A `move_req` still held in that IDLE cycle is accepted as a new move; the car must drop `move_req` on seeing the pulse.
- **Reset mid-move:** the asynchronous reset immediately forces IDLE. `location` reloads from `init_floor`, any pending pulse is lost, and `fault` clears.
- **Door opening in the ARRIVE cycle:** the pulse is still high that cycle. The next edge goes to FAULT without a location update.

## Test plan
- **Single up move:** reset with `init_floor = 0`, hold `move_req = 1`, `move_dir = UP`, `door_closed = 1` → `inc` high for exactly one cycle, 5 edges after accept; `location` becomes 1; `dec` is never high.
- **Full traverse:** up twice to floor 2, then a DOWN request → `dec` after 5 edges, `location = 1`. An UP request at floor 2 → `reject` pulses every cycle, `location` stays 2, `moving` stays 0.
- **Door interlock:** drop `door_closed` two cycles into TRAVEL → FAULT; `fault = 1` sticky, `location` unchanged, no `inc`. A later `move_req` is ignored. Asserting `reset` clears `fault`.
- **Door not closed at request:** `move_req = 1`, `door_closed = 0` for 3 cycles, then 1 → accept on the first closed edge; no `reject`.
- **Clamp and reset mid-move:** `init_floor = 3` → `location = 2` after reset. Start a DOWN move and assert `reset` mid-LEVEL → `location = 2`, `moving = 0`, no `dec`.
- **Parameters:** `TRAVEL_CYCLES = 1`, `LEVEL_CYCLES = 1` → pulse 2 edges after accept. Held `move_req` → second accept after exactly one IDLE cycle.
